pipelined_odd_multiple_precomputer: RTL and testbench

- Parametrised, pipelined successor to the combinational odd-multiple precomputer in the shift-add FIR datapath.
- Produces the odd multiples 1x, 3x, ..., (2*NUM_MULT-1)x of one input sample on a single registered output bus.
- Adds valid/ready flow control with back-pressure, a signed/unsigned mode, a per-multiple overflow flag and a synchronous flush.
- Sits between the sample front-end and the partial-product select/accumulate stages.

---
 rtl/pipelined_odd_multiple_precomputer.sv | 121 ++++++++++++
 tb/tb_pipelined_odd_multiple_precomputer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_odd_multiple_precomputer.sv
// Pipelined odd-multiple precomputer: (2k+1)*x for k = 0..NUM_MULT-1 on one registered bus,
// with valid/ready flow control, signed/unsigned extension, per-multiple overflow flags and flush.
module pipelined_odd_multiple_precomputer #(
  parameter int IN_DATA_WIDTH  = 17,
  parameter int OUT_DATA_WIDTH = 21,
  parameter int NUM_MULT       = 8,
  parameter int SIGNED         = 0,
  parameter int PIPE_STAGES    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_DATA_WIDTH-1:0]           in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_MULT*OUT_DATA_WIDTH-1:0] mult_bus,
  output logic [NUM_MULT-1:0]                ovf_flags
);

  // Wide enough to hold 31x of either the input or an output-width value exactly.
  localparam int W   = ((IN_DATA_WIDTH > OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH) + 5;
  localparam int EXT = W - IN_DATA_WIDTH;

  function automatic logic f_ovf(input logic [W-1:0] p);
    logic r;
    if (SIGNED != 0) begin
      r = !((&p[W-1:OUT_DATA_WIDTH-1]) || !(|p[W-1:OUT_DATA_WIDTH-1]));
    end else begin
      r = |p[W-1:OUT_DATA_WIDTH];
    end
    return r;
  endfunction

  logic [W-1:0]                       w_ext;
  logic [W-1:0]                       w_src;
  logic [W-1:0]                       w_acc;
  logic [NUM_MULT*OUT_DATA_WIDTH-1:0] w_bus;
  logic [NUM_MULT-1:0]                w_ovf;
  logic                               w_out_adv;
  logic                               w_feed_v;

  logic                               r_out_v;
  logic [NUM_MULT*OUT_DATA_WIDTH-1:0] r_bus;
  logic [NUM_MULT-1:0]                r_ovf;

  generate
    if (SIGNED != 0) begin : g_sext
      assign w_ext = {{EXT{in_data[IN_DATA_WIDTH-1]}}, in_data};
    end else begin : g_zext
      assign w_ext = {{EXT{1'b0}}, in_data};
    end
  endgenerate

  // Odd multiples by repeated addition of 2x: m(k) = m(k-1) + 2x, so no multiplier is needed.
  always_comb begin
    w_bus = '0;
    w_ovf = '0;
    w_acc = w_src;
    for (int k = 0; k < NUM_MULT; k++) begin
      w_bus[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = w_acc[OUT_DATA_WIDTH-1:0];
      w_ovf[k] = f_ovf(w_acc);
      w_acc    = w_acc + {w_src[W-2:0], 1'b0};
    end
  end

  assign w_out_adv = !r_out_v || out_ready;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic         r_v1;
      logic [W-1:0] r_x;

      assign in_ready = !r_v1 || w_out_adv;
      assign w_feed_v = r_v1;
      assign w_src    = r_x;

      // Stage 1: extended sample register; only loads when its contents can move on.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v1 <= 1'b0;
          r_x  <= '0;
        end else if (flush) begin
          r_v1 <= 1'b0;
        end else if (in_ready) begin
          r_v1 <= in_valid;
          if (in_valid) begin
            r_x <= w_ext;
          end
        end
      end
    end else begin : g_one
      assign in_ready = w_out_adv;
      assign w_feed_v = in_valid;
      assign w_src    = w_ext;
    end
  endgenerate

  // Output stage: multiples and flags load together so they stay aligned through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_bus   <= '0;
      r_ovf   <= '0;
    end else if (flush) begin
      r_out_v <= 1'b0;
    end else if (w_out_adv) begin
      r_out_v <= w_feed_v;
      if (w_feed_v) begin
        r_bus <= w_bus;
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_v;
  assign mult_bus  = r_bus;
  assign ovf_flags = r_ovf;

endmodule

// File: tb/tb_pipelined_odd_multiple_precomputer.sv
// Scoreboard bench: two instances (unsigned/8/2-stage and signed/16/1-stage) share stimulus;
// expected results come from an integer-arithmetic model and are checked by monitors.
module tb_pipelined_odd_multiple_precomputer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [16:0] in_data;

  logic         a_in_ready, a_out_valid;
  logic [167:0] a_bus;
  logic [7:0]   a_ovf;
  logic         b_in_ready, b_out_valid;
  logic [335:0] b_bus;
  logic [15:0]  b_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [335:0] bus;
    logic [15:0]  ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  pipelined_odd_multiple_precomputer #(
    .IN_DATA_WIDTH(17), .OUT_DATA_WIDTH(21), .NUM_MULT(8), .SIGNED(0), .PIPE_STAGES(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .mult_bus(a_bus), .ovf_flags(a_ovf)
  );

  pipelined_odd_multiple_precomputer #(
    .IN_DATA_WIDTH(17), .OUT_DATA_WIDTH(21), .NUM_MULT(16), .SIGNED(1), .PIPE_STAGES(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .mult_bus(b_bus), .ovf_flags(b_ovf)
  );

  always #5 clk = ~clk;

  // Exact products in 64-bit integers, then wrapped to 21 bits and range-checked.
  function automatic exp_t model(input logic [16:0] d, input int nm, input bit sgn);
    exp_t   e;
    longint x;
    longint p;
    e = '0;
    x = longint'(d);
    if (sgn && d[16]) x = x - 64'sd131072;
    for (int k = 0; k < nm; k++) begin
      p = longint'(2 * k + 1) * x;
      e.bus[k*21 +: 21] = p[20:0];
      if (sgn) e.ovf[k] = (p < -64'sd1048576) || (p > 64'sd1048575);
      else     e.ovf[k] = (p >= 64'sd2097152);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [335:0] act, input logic [335:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Expected responses are queued for every accepted input.
  always @(negedge clk) begin
    if (rst_n && !flush && in_valid) begin
      if (a_in_ready) qa.push_back(model(in_data, 8, 1'b0));
      if (b_in_ready) qb.push_back(model(in_data, 16, 1'b1));
    end
  end

  // A flush edge discards everything in flight.
  always @(posedge clk) begin
    if (rst_n && flush) begin
      qa.delete();
      qb.delete();
    end
  end

  // Monitor A: every cycle with out_valid is compared; a held output is re-compared while stalled.
  always @(negedge clk) begin
    if (rst_n && a_out_valid) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_spurious: out_valid=1 expected no pending result");
      end else begin
        check("a_bus", a_bus, qa[0].bus[167:0]);
        check("a_ovf", a_ovf, qa[0].ovf[7:0]);
        if (out_ready) void'(qa.pop_front());
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (rst_n && b_out_valid) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_spurious: out_valid=1 expected no pending result");
      end else begin
        check("b_bus", b_bus, qb[0].bus);
        check("b_ovf", b_ovf, qb[0].ovf);
        if (out_ready) void'(qb.pop_front());
      end
    end
  end

  // Present one sample until instance A accepts it, then drop in_valid.
  task automatic send(input logic [16:0] d);
    bit acc;
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    done     = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      acc = a_in_ready;
      tick();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("a_drained", qa.size(), 0);
    check("b_drained", qb.size(), 0);
  endtask

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       in_data = 17'h1FFFF;
        1:       in_data = 17'h10000;
        2:       in_data = 17'h0FFFF;
        3:       in_data = 17'h00000;
        default: in_data = 17'($urandom);
      endcase
      tick();
    end
  endtask

  initial begin
    int   n_acc;
    bit   acc;
    logic [16:0] d;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = 17'h0;
    #1;
    check("rst_a_valid", a_out_valid, 1'b0);
    check("rst_a_bus", a_bus, 168'h0);
    check("rst_a_ovf", a_ovf, 8'h0);
    check("rst_b_valid", b_out_valid, 1'b0);
    #11 rst_n = 1'b1;
    tick();
    check("rst_a_ready", a_in_ready, 1'b1);
    check("rst_b_ready", b_in_ready, 1'b1);

    // Unsigned all-ones: A shows it one edge after acceptance, B on the accept edge.
    send(17'h1FFFF);
    check("lat_a_not_yet", a_out_valid, 1'b0);
    check("lat_b_now", b_out_valid, 1'b1);
    check("b_m1_slice7", b_bus[7*21 +: 21], 21'h1FFFF1);
    tick();
    check("lat_a_valid", a_out_valid, 1'b1);
    check("a_slice0", a_bus[0 +: 21], 21'd131071);
    check("a_slice3", a_bus[3*21 +: 21], 21'd917497);
    check("a_slice7", a_bus[7*21 +: 21], 21'd1966065);
    check("a_ovf_none", a_ovf, 8'h00);
    drain();

    // Signed -5 on B.
    send(17'h1FFFB);
    check("b_m5_slice7", b_bus[7*21 +: 21], 21'h1FFFB5);
    check("b_m5_slice1", b_bus[1*21 +: 21], 21'h1FFFF1);
    check("b_m5_ovf", b_ovf, 16'h0000);
    drain();

    // Largest positive signed value: 17x and above leave the 21-bit signed range.
    send(17'h0FFFF);
    check("b_pos_ovf", b_ovf, 16'hFF00);
    check("b_pos_slice15", b_bus[15*21 +: 21], 21'd2031585);
    drain();

    // Back-pressure: samples 1..4 with the sink stalled for five cycles.
    out_ready = 1'b0;
    n_acc     = 0;
    d         = 17'd1;
    in_valid  = 1'b1;
    in_data   = d;
    repeat (5) begin
      @(negedge clk);
      acc = a_in_ready;
      tick();
      if (acc) begin
        n_acc++;
        d = d + 17'd1;
        in_data = d;
      end
    end
    check("bp_accepts", n_acc, 2);
    check("bp_in_ready_low", a_in_ready, 1'b0);
    check("bp_hold_valid", a_out_valid, 1'b1);
    check("bp_hold_slice0", a_bus[0 +: 21], 21'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && d <= 17'd4; i++) begin
      @(negedge clk);
      acc = a_in_ready;
      tick();
      if (acc) begin
        d = d + 17'd1;
        in_data = d;
      end
    end
    in_valid = 1'b0;
    check("bp_all_sent", d, 17'd5);
    drain();

    // Flush with two samples in flight; the input presented with the flush is dropped.
    out_ready = 1'b0;
    send(17'd5);
    send(17'd6);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 17'd99;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_a_valid", a_out_valid, 1'b0);
    check("flush_b_valid", b_out_valid, 1'b0);
    out_ready = 1'b1;
    send(17'd7);
    check("flush_b_slice2", b_bus[2*21 +: 21], 21'd35);
    check("flush_a_latency", a_out_valid, 1'b0);
    tick();
    check("flush_a_valid7", a_out_valid, 1'b1);
    check("flush_a_slice2", a_bus[2*21 +: 21], 21'd35);
    drain();

    random_phase(300);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    in_valid = 1'b0;
    check("arst_a_valid", a_out_valid, 1'b0);
    check("arst_a_bus", a_bus, 168'h0);
    check("arst_a_ovf", a_ovf, 8'h0);
    check("arst_b_valid", b_out_valid, 1'b0);
    check("arst_b_bus", b_bus, 336'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("arst_a_ready", a_in_ready, 1'b1);
    check("arst_b_ready", b_in_ready, 1'b1);

    random_phase(200);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
